// File: rtl/wb_write_queue.sv
// -----------------------------------------------------------------------------
// wb_write_queue
//   Four-entry write-back queue sitting between a producer of register writes
//   and a single register-file write port. Accepted writes drain in FIFO order
//   whenever the write port is free, and pending writes are forwarded to two
//   read ports so readers never observe stale register-file contents.
//
// Ports
//   clk                : single clock, rising edge
//   rst                : asynchronous, active-high reset
//   InValid/InReg/InData/InReady : producer handshake (reg number + data)
//   Stall              : register-file write port busy, hold the head entry
//   WriteReg/DstReg/DstData      : register-file write port
//   SrcReg1/SrcReg2    : registers being read this cycle
//   FwdHit1/2, FwdData1/2        : youngest pending write to each read reg
//   Count              : number of valid entries, 0..4
// -----------------------------------------------------------------------------
module wb_write_queue #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        InValid,
  input  logic [3:0]  InReg,
  input  logic [15:0] InData,
  output logic        InReady,
  input  logic        Stall,
  output logic        WriteReg,
  output logic [3:0]  DstReg,
  output logic [15:0] DstData,
  input  logic [3:0]  SrcReg1,
  input  logic [3:0]  SrcReg2,
  output logic        FwdHit1,
  output logic        FwdHit2,
  output logic [15:0] FwdData1,
  output logic [15:0] FwdData2,
  output logic [2:0]  Count
);

  // Entry storage holds data only; validity is derived from head and count,
  // so it never needs a reset.
  logic [3:0][3:0]  reg_q;
  logic [3:0][15:0] data_q;

  logic [1:0] head_q, head_d;
  logic [1:0] tail_q, tail_d;
  logic [2:0] count_q, count_d;

  logic enq;
  logic deq;

  logic [16:0] fwd1;
  logic [16:0] fwd2;

  // Walk entries from oldest to youngest so the last match wins; the walk is
  // relative to head, which makes pointer wrap-around transparent.
  function automatic logic [16:0] fwd_lookup(
    input logic [3:0]       src,
    input logic [1:0]       head,
    input logic [2:0]       cnt,
    input logic [3:0][3:0]  regs,
    input logic [3:0][15:0] datas
  );
    logic        hit;
    logic [15:0] data;
    logic [1:0]  idx;
    hit  = 1'b0;
    data = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      idx = head + 2'(k);
      if ((3'(k) < cnt) && (regs[idx] == src)) begin
        hit  = 1'b1;
        data = datas[idx];
      end
    end
    return {hit, data};
  endfunction

  // InReady depends on the registered count only: a full queue never takes a
  // new write in the same cycle it drains one.
  assign InReady  = (count_q < 3'(DEPTH));
  assign WriteReg = (count_q != 3'd0) && !Stall;
  assign DstReg   = (count_q != 3'd0) ? reg_q[head_q]  : 4'h0;
  assign DstData  = (count_q != 3'd0) ? data_q[head_q] : 16'h0000;
  assign Count    = count_q;

  assign enq = InValid && InReady;
  assign deq = WriteReg;

  // The entry enqueued this cycle is not yet counted, so it is naturally
  // excluded from forwarding.
  assign fwd1     = fwd_lookup(SrcReg1, head_q, count_q, reg_q, data_q);
  assign fwd2     = fwd_lookup(SrcReg2, head_q, count_q, reg_q, data_q);
  assign FwdHit1  = fwd1[16];
  assign FwdData1 = fwd1[15:0];
  assign FwdHit2  = fwd2[16];
  assign FwdData2 = fwd2[15:0];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d = tail_q + 2'd1;
    end
    if (deq) begin
      head_d = head_q + 2'd1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= 2'd0;
      tail_q  <= 2'd0;
      count_q <= 3'd0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      reg_q[tail_q]  <= InReg;
      data_q[tail_q] <= InData;
    end
  end

endmodule

// File: tb/tb_wb_write_queue.sv
module tb_wb_write_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        InValid = 1'b0;
  logic [3:0]  InReg = 4'h0;
  logic [15:0] InData = 16'h0000;
  logic        InReady;
  logic        Stall = 1'b0;
  logic        WriteReg;
  logic [3:0]  DstReg;
  logic [15:0] DstData;
  logic [3:0]  SrcReg1 = 4'h0;
  logic [3:0]  SrcReg2 = 4'h0;
  logic        FwdHit1, FwdHit2;
  logic [15:0] FwdData1, FwdData2;
  logic [2:0]  Count;

  int errors = 0;
  int checks = 0;

  // Scoreboard of accepted-but-not-written entries {reg, data}, oldest first.
  logic [19:0] sb[$];
  // Log of writes actually issued by the DUT.
  logic [19:0] wlog[$];

  wb_write_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .InValid(InValid), .InReg(InReg), .InData(InData), .InReady(InReady),
    .Stall(Stall), .WriteReg(WriteReg), .DstReg(DstReg), .DstData(DstData),
    .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
    .FwdHit1(FwdHit1), .FwdHit2(FwdHit2),
    .FwdData1(FwdData1), .FwdData2(FwdData2),
    .Count(Count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required=<200000", $time);
    $fatal(1, "watchdog");
  end

  function automatic void fwd_model(input logic [3:0] src, output logic hit, output logic [15:0] data);
    hit  = 1'b0;
    data = 16'h0000;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i][19:16] == src) begin
        hit  = 1'b1;
        data = sb[i][15:0];
        break;
      end
    end
  endfunction

  // Mid-cycle monitor: inputs change #1 after posedge, outputs sampled here.
  logic        m_wr, m_rdy, m_h1, m_h2;
  logic [2:0]  m_cnt;
  logic [19:0] m_dst;
  logic [15:0] m_d1, m_d2;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (WriteReg !== 1'b0 || Count !== 3'd0 || InReady !== 1'b1 || DstReg !== 4'h0 ||
          DstData !== 16'h0 || FwdHit1 !== 1'b0 || FwdHit2 !== 1'b0 ||
          FwdData1 !== 16'h0 || FwdData2 !== 16'h0) begin
        errors++;
        $display("FAIL reset_outputs: wr=%b cnt=%0d rdy=%b dst=%h/%h hit=%b%b fwd=%h/%h required wr=0 cnt=0 rdy=1 rest 0",
                 WriteReg, Count, InReady, DstReg, DstData, FwdHit1, FwdHit2, FwdData1, FwdData2);
      end
      sb.delete();
    end else begin
      m_cnt = 3'(sb.size());
      m_rdy = (sb.size() < 4);
      m_wr  = (sb.size() != 0) && !Stall;
      m_dst = (sb.size() != 0) ? sb[0] : 20'h0;
      fwd_model(SrcReg1, m_h1, m_d1);
      fwd_model(SrcReg2, m_h2, m_d2);
      checks++;
      if (Count !== m_cnt) begin
        errors++; $display("FAIL count: got %0d required %0d", Count, m_cnt);
      end
      checks++;
      if (InReady !== m_rdy) begin
        errors++; $display("FAIL inready: got %b required %b", InReady, m_rdy);
      end
      checks++;
      if (WriteReg !== m_wr) begin
        errors++; $display("FAIL writereg: got %b required %b", WriteReg, m_wr);
      end
      checks++;
      if ({DstReg, DstData} !== m_dst) begin
        errors++; $display("FAIL dst_head: got %h/%h required %h/%h", DstReg, DstData, m_dst[19:16], m_dst[15:0]);
      end
      checks++;
      if (FwdHit1 !== m_h1 || FwdData1 !== m_d1) begin
        errors++; $display("FAIL fwd1: src=%h got %b/%h required %b/%h", SrcReg1, FwdHit1, FwdData1, m_h1, m_d1);
      end
      checks++;
      if (FwdHit2 !== m_h2 || FwdData2 !== m_d2) begin
        errors++; $display("FAIL fwd2: src=%h got %b/%h required %b/%h", SrcReg2, FwdHit2, FwdData2, m_h2, m_d2);
      end
      if (WriteReg === 1'b1) wlog.push_back({DstReg, DstData});
      if (m_wr) void'(sb.pop_front());
      if (InValid && m_rdy) sb.push_back({InReg, InData});
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      InValid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (Count !== 3'd0 || InReady !== 1'b1 || WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: cnt=%0d rdy=%b wr=%b required 0/1/0", Count, InReady, WriteReg);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    // First edge after reset release accepts the write.
    InValid = 1'b1; InReg = 4'd3; InData = 16'hABCD; Stall = 1'b0;
    @(posedge clk); #1;
    InValid = 1'b0;
    checks++;
    if (WriteReg !== 1'b1 || DstReg !== 4'd3 || DstData !== 16'hABCD || Count !== 3'd1) begin
      errors++;
      $display("FAIL single_write: wr=%b dst=%h/%h cnt=%0d required 1 3/abcd 1", WriteReg, DstReg, DstData, Count);
    end
    @(posedge clk); #1;
    checks++;
    if (Count !== 3'd0 || WriteReg !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: cnt=%0d wr=%b required 0/0", Count, WriteReg);
    end
  endtask

  task automatic test_full();
    wlog.delete();
    Stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      InValid = 1'b1; InReg = 4'(i); InData = 16'(16'h0011 * i);
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    checks++;
    if (Count !== 3'd4 || InReady !== 1'b0) begin
      errors++;
      $display("FAIL full_state: cnt=%0d rdy=%b required 4/0", Count, InReady);
    end
    Stall = 1'b0;
    idle(5);
    checks++;
    if (wlog.size() != 4) begin
      errors++;
      $display("FAIL full_write_count: got %0d required 4", wlog.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wlog[i] !== {4'(i + 1), 16'(16'h0011 * (i + 1))}) begin
          errors++;
          $display("FAIL full_order[%0d]: got %h required %h", i, wlog[i], {4'(i + 1), 16'(16'h0011 * (i + 1))});
        end
      end
    end
  endtask

  task automatic test_forward();
    Stall = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b1; InReg = 4'd7; InData = 16'h1111;
    @(posedge clk); #1;
    InData = 16'h2222;
    @(posedge clk); #1;
    InValid = 1'b0; SrcReg1 = 4'd7; SrcReg2 = 4'd8;
    #1;
    checks++;
    if (FwdHit1 !== 1'b1 || FwdData1 !== 16'h2222 || FwdHit2 !== 1'b0 || FwdData2 !== 16'h0000) begin
      errors++;
      $display("FAIL fwd_youngest: hit1=%b d1=%h hit2=%b d2=%h required 1 2222 0 0000",
               FwdHit1, FwdData1, FwdHit2, FwdData2);
    end
    Stall = 1'b0;
    idle(4);
  endtask

  task automatic test_stream();
    int sent = 0;
    int cyc  = 0;
    wlog.delete();
    while ((sent < 10 || sb.size() != 0) && cyc < 80) begin
      @(posedge clk); #1;
      Stall = ((cyc / 2) % 2) == 1;
      if (sent < 10) begin
        InValid = 1'b1; InReg = 4'((sent % 3) + 2); InData = 16'(16'h1000 + sent);
      end else begin
        InValid = 1'b0;
      end
      SrcReg1 = 4'((sent % 3) + 2);
      SrcReg2 = 4'(((sent + 1) % 3) + 2);
      #3;
      if (InValid && InReady) sent++;
      cyc++;
    end
    @(posedge clk); #1;
    InValid = 1'b0; Stall = 1'b0;
    checks++;
    if (sent != 10 || sb.size() != 0) begin
      errors++;
      $display("FAIL stream_timeout: sent=%0d pending=%0d required 10/0", sent, sb.size());
    end
    checks++;
    if (wlog.size() != 10) begin
      errors++;
      $display("FAIL stream_write_count: got %0d required 10", wlog.size());
    end else begin
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (wlog[i] !== {4'((i % 3) + 2), 16'(16'h1000 + i)}) begin
          errors++;
          $display("FAIL stream_order[%0d]: got %h required %h", i, wlog[i], {4'((i % 3) + 2), 16'(16'h1000 + i)});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    Stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      InValid = 1'b1; InReg = 4'(9 + i); InData = 16'(16'hC000 + i);
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    checks++;
    if (Count !== 3'd3) begin
      errors++;
      $display("FAIL mid_prefill: cnt=%0d required 3", Count);
    end
    wlog.delete();
    @(posedge clk); #3;
    rst = 1'b1; Stall = 1'b0; SrcReg1 = 4'd9; SrcReg2 = 4'd10;
    #1;
    checks++;
    if (Count !== 3'd0 || InReady !== 1'b1 || WriteReg !== 1'b0 || DstData !== 16'h0 || FwdHit1 !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_async: cnt=%0d rdy=%b wr=%b dd=%h hit1=%b required 0 1 0 0000 0",
               Count, InReady, WriteReg, DstData, FwdHit1);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(4);
    checks++;
    if (wlog.size() != 0) begin
      errors++;
      $display("FAIL mid_no_write: got %0d writes required 0", wlog.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_full();
    test_forward();
    test_stream();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
